// File: rtl/hazard_ctrl_if.sv
// Control bundle between the decode/execute stages and the hazard controller.
// The slave side is the controller; the master side is the pipeline that uses it.
interface hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        ID_rs;
  logic [4:0]        ID_rt;
  logic              ID_uses_rs;
  logic              ID_uses_rt;
  logic              ID_jump;
  logic              ID_is_muldiv;
  logic              EX_MemRead;
  logic [4:0]        EX_dst;
  logic              EX_branch_taken;
  logic              PC_write;
  logic              IF_ID_stall;
  logic              IF_ID_flush;
  logic              ID_EX_flush;
  logic              muldiv_busy;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_jump, ID_is_muldiv,
           EX_MemRead, EX_dst, EX_branch_taken,
    input  PC_write, IF_ID_stall, IF_ID_flush, ID_EX_flush, muldiv_busy, stall_cycles
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_jump, ID_is_muldiv,
           EX_MemRead, EX_dst, EX_branch_taken,
    output PC_write, IF_ID_stall, IF_ID_flush, ID_EX_flush, muldiv_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, and a
// mul/div occupancy FSM that holds the front end while the unit is busy.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 4,
  parameter int PERF_W        = 16
) (
  input  logic           clk,
  input  logic           reset,
  hazard_ctrl_if.slave   hc
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PERF_W-1:0] stall_cnt;
  logic              lu;
  logic              pc_write, if_id_stall, if_id_flush, id_ex_flush, busy;

  assign lu = hc.EX_MemRead && (hc.EX_dst != 5'd0) &&
              ((hc.ID_uses_rs && (hc.ID_rs == hc.EX_dst)) ||
               (hc.ID_uses_rt && (hc.ID_rt == hc.EX_dst)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        // A mul/div only issues when nothing of higher priority claims the cycle.
        if (!hc.EX_branch_taken && !lu && !hc.ID_jump && hc.ID_is_muldiv) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    busy        = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (hc.EX_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_write    = 1'b1;
          end else if (lu) begin
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hc.ID_jump) begin
            if_id_flush = 1'b1;
            pc_write    = 1'b1;
          end else begin
            pc_write    = 1'b1;
          end
        end
        MD_BUSY: begin
          busy        = 1'b1;
          id_ex_flush = 1'b1;
          // A stray taken branch still redirects fetch; the unit keeps counting.
          if (hc.EX_branch_taken) begin
            if_id_flush = 1'b1;
            pc_write    = 1'b1;
          end else begin
            if_id_stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                stall_cnt <= '0;
    else if (if_id_stall && stall_cnt != PERF_MAX) stall_cnt <= stall_cnt + PERF_W'(1);
  end

  assign hc.PC_write     = pc_write;
  assign hc.IF_ID_stall  = if_id_stall;
  assign hc.IF_ID_flush  = if_id_flush;
  assign hc.ID_EX_flush  = id_ex_flush;
  assign hc.muldiv_busy  = busy;
  assign hc.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model checked every cycle.
module tb_hazard_ctrl;

  localparam int MULDIV_CYCLES = 4;
  localparam int PERF_W        = 4;
  localparam int MAXC          = (1 << PERF_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.PERF_W(PERF_W)) hif ();

  hazard_ctrl #(
    .MULDIV_CYCLES(MULDIV_CYCLES),
    .CNT_W        (4),
    .PERF_W       (PERF_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hc   (hif.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining stall cycles owed to an issued mul/div, and a
  // saturating tally of stalled cycles.
  int m_busy_left = 0, m_stalls = 0;
  int n_busy_left = 0, n_stalls = 0;

  always @(negedge clk) begin
    logic e_pc, e_st, e_fl, e_idex, e_busy, m_lu;
    m_lu = hif.EX_MemRead && (hif.EX_dst != 5'd0) &&
           ((hif.ID_uses_rs && hif.ID_rs == hif.EX_dst) ||
            (hif.ID_uses_rt && hif.ID_rt == hif.EX_dst));
    {e_pc, e_st, e_fl, e_idex, e_busy} = '0;
    n_busy_left = m_busy_left;
    if (reset) begin
      n_busy_left = 0;
    end else if (m_busy_left > 0) begin
      e_busy = 1'b1;
      e_idex = 1'b1;
      if (hif.EX_branch_taken) begin e_fl = 1'b1; e_pc = 1'b1; end
      else                           e_st = 1'b1;
      n_busy_left = m_busy_left - 1;
    end else if (hif.EX_branch_taken) begin
      e_fl = 1'b1; e_idex = 1'b1; e_pc = 1'b1;
    end else if (m_lu) begin
      e_st = 1'b1; e_idex = 1'b1;
    end else if (hif.ID_jump) begin
      e_fl = 1'b1; e_pc = 1'b1;
    end else begin
      e_pc = 1'b1;
      if (hif.ID_is_muldiv) n_busy_left = MULDIV_CYCLES - 1;
    end
    n_stalls = (m_stalls + int'(e_st) > MAXC) ? MAXC : m_stalls + int'(e_st);
    check("m_pc_write",     32'(hif.PC_write),     32'(e_pc));
    check("m_if_id_stall",  32'(hif.IF_ID_stall),  32'(e_st));
    check("m_if_id_flush",  32'(hif.IF_ID_flush),  32'(e_fl));
    check("m_id_ex_flush",  32'(hif.ID_EX_flush),  32'(e_idex));
    check("m_muldiv_busy",  32'(hif.muldiv_busy),  32'(e_busy));
    check("m_stall_cycles", 32'(hif.stall_cycles), reset ? 32'd0 : 32'(m_stalls));
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy_left = 0;
      m_stalls    = 0;
    end else begin
      m_busy_left = n_busy_left;
      m_stalls    = n_stalls;
    end
  end

  task automatic idle();
    hif.ID_rs = '0; hif.ID_rt = '0; hif.ID_uses_rs = 1'b0; hif.ID_uses_rt = 1'b0;
    hif.ID_jump = 1'b0; hif.ID_is_muldiv = 1'b0; hif.EX_MemRead = 1'b0;
    hif.EX_dst = '0; hif.EX_branch_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] dst);
    hif.EX_MemRead = 1'b1; hif.EX_dst = dst; hif.ID_uses_rs = 1'b1; hif.ID_rs = dst;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_write", 32'(hif.PC_write), 32'd0);
    check("rst_stall_cycles", 32'(hif.stall_cycles), 32'd0);
    reset = 1'b0;
    #1 check("run_pc_write", 32'(hif.PC_write), 32'd1);

    // Load-use on rs, one cycle only.
    step(); set_lu(5'd8); #1;
    check("lu_stall", 32'(hif.IF_ID_stall), 32'd1);
    check("lu_pc_write", 32'(hif.PC_write), 32'd0);
    check("lu_id_ex_flush", 32'(hif.ID_EX_flush), 32'd1);
    step(); idle(); #1;
    check("lu_stall_cycles", 32'(hif.stall_cycles), 32'd1);
    check("lu_released", 32'(hif.IF_ID_stall), 32'd0);

    // Load to r0 never stalls.
    step(); set_lu(5'd0); #1;
    check("r0_stall", 32'(hif.IF_ID_stall), 32'd0);
    check("r0_pc_write", 32'(hif.PC_write), 32'd1);

    // Branch beats load-use.
    step(); idle(); set_lu(5'd8); hif.EX_branch_taken = 1'b1; #1;
    check("br_if_id_flush", 32'(hif.IF_ID_flush), 32'd1);
    check("br_stall", 32'(hif.IF_ID_stall), 32'd0);
    check("br_pc_write", 32'(hif.PC_write), 32'd1);

    // Jump held by load-use, then taken.
    step(); idle(); set_lu(5'd8); hif.ID_jump = 1'b1; #1;
    check("jlu_stall", 32'(hif.IF_ID_stall), 32'd1);
    check("jlu_flush", 32'(hif.IF_ID_flush), 32'd0);
    step(); hif.EX_MemRead = 1'b0; #1;
    check("j_flush", 32'(hif.IF_ID_flush), 32'd1);
    check("j_pc_write", 32'(hif.PC_write), 32'd1);
    check("j_id_ex_flush", 32'(hif.ID_EX_flush), 32'd0);

    // Load-use through rt; rt match ignored when rt unused.
    step(); idle(); hif.EX_MemRead = 1'b1; hif.EX_dst = 5'd5; hif.ID_rt = 5'd5;
    hif.ID_uses_rt = 1'b1; #1;
    check("lu_rt_stall", 32'(hif.IF_ID_stall), 32'd1);
    step(); hif.ID_uses_rt = 1'b0; #1;
    check("rt_unused_stall", 32'(hif.IF_ID_stall), 32'd0);

    // Mul/div from a fresh counter.
    step(); idle(); reset = 1'b1; #1; reset = 1'b0;
    hif.ID_is_muldiv = 1'b1; #1;
    check("md0_stall", 32'(hif.IF_ID_stall), 32'd0);
    check("md0_pc_write", 32'(hif.PC_write), 32'd1);
    step(); hif.ID_is_muldiv = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check("md_busy", 32'(hif.muldiv_busy), 32'd1);
      check("md_stall", 32'(hif.IF_ID_stall), 32'd1);
      check("md_pc_write", 32'(hif.PC_write), 32'd0);
      step();
    end
    #1;
    check("md4_busy", 32'(hif.muldiv_busy), 32'd0);
    check("md4_pc_write", 32'(hif.PC_write), 32'd1);
    check("md4_stall_cycles", 32'(hif.stall_cycles), 32'd3);

    // Taken branch during busy: flush instead of stall, counting continues.
    hif.ID_is_muldiv = 1'b1; step(); hif.ID_is_muldiv = 1'b0; hif.EX_branch_taken = 1'b1; #1;
    check("mdbr_flush", 32'(hif.IF_ID_flush), 32'd1);
    check("mdbr_stall", 32'(hif.IF_ID_stall), 32'd0);
    check("mdbr_busy", 32'(hif.muldiv_busy), 32'd1);
    step(); hif.EX_branch_taken = 1'b0; step(); step(); #1;
    check("mdbr_done", 32'(hif.muldiv_busy), 32'd0);

    // Mul/div waiting in ID re-issues once busy ends; jump ignored while busy.
    hif.ID_is_muldiv = 1'b1; step(); hif.ID_jump = 1'b1; #1;
    check("mdj_flush", 32'(hif.IF_ID_flush), 32'd0);
    hif.ID_jump = 1'b0; step(); step(); step(); #1;
    check("mdre_busy", 32'(hif.muldiv_busy), 32'd0);
    step(); #1;
    check("mdre_busy2", 32'(hif.muldiv_busy), 32'd1);
    idle(); repeat (3) step();

    // Reset in the middle of busy.
    hif.ID_is_muldiv = 1'b1; step(); hif.ID_is_muldiv = 1'b0; step(); #1;
    check("mdr_busy_pre", 32'(hif.muldiv_busy), 32'd1);
    reset = 1'b1; #1;
    check("mdr_busy", 32'(hif.muldiv_busy), 32'd0);
    check("mdr_stall_cycles", 32'(hif.stall_cycles), 32'd0);
    check("mdr_pc_write", 32'(hif.PC_write), 32'd0);
    step(); reset = 1'b0; #1;
    check("mdr_after_pc", 32'(hif.PC_write), 32'd1);
    check("mdr_after_busy", 32'(hif.muldiv_busy), 32'd0);

    // Saturation of the stall counter.
    step(); set_lu(5'd8);
    repeat (20) step();
    idle(); #1;
    check("sat_stall_cycles", 32'(hif.stall_cycles), 32'(MAXC));

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller that drives the stall and flush inputs of the IF/ID register, the flush of the ID/EX register, and the PC write enable. It detects load-use hazards, branches taken in EX, and jumps resolved in ID. It also tracks a multi-cycle mul/div operation with an FSM and down-counter, holding the front end until the unit is free. A saturating stall-cycle counter is provided for performance monitoring.

Parameters:
MULDIV_CYCLES, 4, total EX occupancy of a mul/div instruction in cycles; legal range 2..15
CNT_W, 4, width of the mul/div down-counter; must satisfy 2^CNT_W > MULDIV_CYCLES
PERF_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
ID_rs  input  5  rs field of the instruction in ID
ID_rt  input  5  rt field of the instruction in ID
ID_uses_rs  input  1  ID instruction reads rs
ID_uses_rt  input  1  ID instruction reads rt
ID_jump  input  1  ID instruction is a jump (j/jal/jr/jalr), resolved in ID
ID_is_muldiv  input  1  ID instruction is a mul/div
EX_MemRead  input  1  EX instruction is a load
EX_dst  input  5  destination register of the EX instruction
EX_branch_taken  input  1  branch in EX resolved taken
PC_write  output  1  PC update enable
IF_ID_stall  output  1  hold the IF/ID register
IF_ID_flush  output  1  zero the IF/ID register
ID_EX_flush  output  1  insert a bubble into ID/EX
muldiv_busy  output  1  FSM is in MD_BUSY
stall_cycles  output  PERF_W  count of cycles with IF_ID_stall=1, saturating

Behaviour:
- Reset is asynchronous, active-high. The FSM goes to RUN, the counter is cleared, and stall_cycles becomes 0.
- While reset is high: PC_write=0, IF_ID_stall=0, IF_ID_flush=0, ID_EX_flush=0, muldiv_busy=0.
- Control outputs are combinational from the current state and inputs, so they take effect in the same cycle. State, counter and stall_cycles are registered.
- Load-use hazard (lu) is true when all of these hold:
  - EX_MemRead=1
  - EX_dst != 0
  - (ID_uses_rs and ID_rs==EX_dst) or (ID_uses_rt and ID_rt==EX_dst)
- State RUN, outputs evaluated in strict priority order:
  1. EX_branch_taken: IF_ID_flush=1, ID_EX_flush=1, PC_write=1. Any lu, jump or mul/div in ID is squashed; no state change.
  2. lu: PC_write=0, IF_ID_stall=1, ID_EX_flush=1. A pending jump or mul/div in ID waits and is re-evaluated next cycle. Exactly one bubble is inserted per load.
  3. ID_jump: IF_ID_flush=1, PC_write=1, ID_EX_flush=0.
  4. ID_is_muldiv: no stall; the instruction advances into EX. Next state is MD_BUSY and cnt is set to MULDIV_CYCLES-1.
  5. Otherwise: PC_write=1 and all other outputs are 0.
- State MD_BUSY:
  - Outputs: PC_write=0, IF_ID_stall=1, ID_EX_flush=1, muldiv_busy=1.
  - Each cycle cnt decrements by 1. When cnt==1, next state is RUN.
  - Result: exactly MULDIV_CYCLES-1 stall cycles follow the mul/div issue cycle.
  - If EX_branch_taken occurs in MD_BUSY (a protocol violation), IF_ID_flush=1 and ID_EX_flush=1 are added, IF_ID_stall is forced to 0, PC_write=1, and counting continues.
  - ID_jump, lu and ID_is_muldiv are ignored in MD_BUSY. A mul/div waiting in ID is evaluated in RUN after busy ends.
- IF_ID_stall and IF_ID_flush are never asserted together.
- stall_cycles increments on each clock edge where IF_ID_stall=1 and saturates at 2^PERF_W-1 without wrap.
- Reset asserted mid-MD_BUSY returns to RUN immediately. The outputs take their reset values asynchronously.

Test Plan:
- Load-use on rs: EX_MemRead=1, EX_dst=8, ID_uses_rs=1, ID_rs=8 for one cycle -> PC_write=0, IF_ID_stall=1, ID_EX_flush=1 for that cycle only; stall_cycles goes 0->1. Repeat with EX_dst=0 -> no stall.
- Branch beats load-use: same load-use inputs plus EX_branch_taken=1 -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1, IF_ID_stall=0.
- Jump held by load-use: ID_jump=1 with lu active -> cycle 1 stall with no flush; next cycle EX_MemRead=0 -> IF_ID_flush=1, PC_write=1.
- Mul/div with MULDIV_CYCLES=4: ID_is_muldiv=1 at cycle 0 -> no stall at cycle 0. Cycles 1-3: muldiv_busy=1, IF_ID_stall=1, PC_write=0. Cycle 4: RUN, all outputs idle; stall_cycles=3.
- Reset mid-busy: assert reset during cycle 2 of MD_BUSY -> muldiv_busy=0 and stall_cycles=0 at once. After deassertion: RUN, PC_write=1.
- Saturation with PERF_W=4: hold lu for 20 cycles -> stall_cycles stops at 15.
